// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the pipeline sequencing controller
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int SB_AW = 8;

    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_read;
        logic [SB_AW-1:0] dest;
    } sb_entry_t;

    typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

    localparam sb_entry_t SB_NOP = '0;

    function automatic logic sb_live(sb_entry_t e);
        return e.valid && e.wb_en && (e.dest != '0);
    endfunction

    function automatic logic sb_match(sb_entry_t e, logic [SB_AW-1:0] s1, logic [SB_AW-1:0] s2, logic two);
        return sb_live(e) && ((s1 == e.dest) || (two && (s2 == e.dest)));
    endfunction

endpackage

// File: rtl/hazard_sched_unit_if.sv
// hazard_sched_unit_if: ID-stage decode, branch and memory-wait signals plus pipeline controls
interface hazard_sched_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_two_src;
    logic              id_wb_en;
    logic [REG_AW-1:0] id_dest;
    logic              id_mem_read;
    logic              ex_branch_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              freeze_pc;
    logic              bubble_idex;
    logic              flush_ifid;
    logic              freeze_all;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_mem_read,
        output ex_branch_taken, mem_req, mem_ready,
        input  freeze_pc, bubble_idex, flush_ifid, freeze_all, stall_cycles
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_mem_read,
        input  ex_branch_taken, mem_req, mem_ready,
        output freeze_pc, bubble_idex, flush_ifid, freeze_all, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination tracking and RAW / load-use match against ID
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int FORWARD_EN = 0,
    parameter int REG_AW     = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              load,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_wb_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_mem_read,
    output logic              hazard
);
    sb_entry_t ex_e, mem_e, wb_e, id_e;
    logic [SB_AW-1:0] s1, s2;

    assign s1 = SB_AW'(id_src1);
    assign s2 = SB_AW'(id_src2);
    assign id_e = '{valid: 1'b1, wb_en: id_wb_en, mem_read: id_mem_read, dest: SB_AW'(id_dest)};

    // With forwarding only a load in EX can't be bypassed; without it any live producer stalls
    assign hazard = id_valid && ((FORWARD_EN != 0)
        ? (ex_e.mem_read && sb_match(ex_e, s1, s2, id_two_src))
        : (sb_match(ex_e, s1, s2, id_two_src) || sb_match(mem_e, s1, s2, id_two_src)
           || sb_match(wb_e, s1, s2, id_two_src)));

    // Advance the three-entry shadow pipeline unless a memory wait freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_e  <= SB_NOP;
            mem_e <= SB_NOP;
            wb_e  <= SB_NOP;
        end else if (!hold) begin
            wb_e  <= mem_e;
            mem_e <= ex_e;
            ex_e  <= load ? id_e : SB_NOP;
        end
    end
endmodule

// File: rtl/hazard_sched_unit.sv
// hazard_sched_unit: 5-stage pipeline hold/bubble/flush sequencing with memory-wait FSM and stall counter
module hazard_sched_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int FORWARD_EN = 0,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic rst,
    hazard_sched_unit_if.slave bus
);
    localparam logic [0:0] ST_RUN      = RUN;
    localparam logic [0:0] ST_MEM_WAIT = MEM_WAIT;

    logic [0:0]       state;
    logic             live, hazard, wait_mem, branch, stall;
    logic [CNT_W-1:0] cnt;

    // Outputs stay quiet for the first cycle after reset release, so everything is gated by live
    assign wait_mem = live && (bus.mem_req || state == ST_MEM_WAIT) && !bus.mem_ready;
    assign branch   = live && !wait_mem && bus.ex_branch_taken;
    assign stall    = live && !wait_mem && !branch && hazard;

    assign bus.freeze_all   = wait_mem;
    assign bus.freeze_pc    = wait_mem || stall;
    assign bus.bubble_idex  = branch || stall;
    assign bus.flush_ifid   = branch;
    assign bus.stall_cycles = cnt;

    hazard_scoreboard #(.FORWARD_EN(FORWARD_EN), .REG_AW(REG_AW)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .hold        (wait_mem),
        .load        (bus.id_valid && !bus.bubble_idex),
        .id_valid    (bus.id_valid),
        .id_src1     (bus.id_src1),
        .id_src2     (bus.id_src2),
        .id_two_src  (bus.id_two_src),
        .id_wb_en    (bus.id_wb_en),
        .id_dest     (bus.id_dest),
        .id_mem_read (bus.id_mem_read),
        .hazard      (hazard)
    );

    // wait_mem already encodes both RUN->MEM_WAIT entry and staying until mem_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            live  <= 1'b0;
        end else begin
            state <= wait_mem ? ST_MEM_WAIT : ST_RUN;
            live  <= 1'b1;
        end
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (bus.freeze_pc && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Keeps an internal scoreboard of destination registers for the instructions in EX, MEM and WB.
- From that it produces the hold (freeze), bubble and flush controls for the IF, ID, ID/EX, EX/MEM and MEM/WB registers.
- It also handles data-memory wait states and taken-branch squashes, and exposes a stall performance counter.

Parameters:
- FORWARD_EN, 0: 1 = forwarding path present, so only load-use hazards stall; 0 = any RAW hazard against EX/MEM/WB stalls.
- REG_AW, 5: register address width.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_AW  ID source register 1 (Instruction[25:21])
- id_src2  in  REG_AW  ID source register 2 (Instruction[20:16])
- id_two_src  in  1  instruction reads src2 as an operand (not immediate)
- id_wb_en  in  1  ID instruction writes the register file
- id_dest  in  REG_AW  ID destination (after Is_imm mux)
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_req  in  1  MEM stage is issuing a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- freeze_pc  out  1  hold PC and the IF/ID register
- bubble_idex  out  1  load a NOP into ID/EX (WB/mem enables cleared)
- flush_ifid  out  1  clear IF/ID
- freeze_all  out  1  hold every pipeline register (memory wait)
- stall_cycles  out  CNT_W  saturating count of cycles with freeze_pc=1

Behaviour:
Reset:
- Scoreboard entries EX/MEM/WB are invalid; FSM = RUN; stall_cycles = 0.
- All outputs are 0 while rst is asserted and on the first cycle after release.

Scoreboard:
- Three entries: {valid, wb_en, dest, mem_read}.
- An entry hazards only when valid && wb_en && dest != 0.

Hazard detection (combinational, same cycle as ID decode):
- match(e) = (id_src1 == e.dest) || (id_two_src && id_src2 == e.dest).
- FORWARD_EN=0: hazard = id_valid && (match(EX) || match(MEM) || match(WB)), with each entry qualified as above.
- FORWARD_EN=1: hazard = id_valid && EX.mem_read && match(EX).

FSM states RUN and MEM_WAIT:
- RUN -> MEM_WAIT when mem_req && !mem_ready.
- MEM_WAIT -> RUN on mem_ready.
- A single-cycle access (mem_req && mem_ready in the same cycle) stays in RUN.
- freeze_all = (RUN && mem_req && !mem_ready) || (MEM_WAIT && !mem_ready).

Output priority, highest first:
1. freeze_all=1: freeze_pc=1, bubble_idex=0, flush_ifid=0; scoreboard holds. A taken branch is not lost, because EX is held and ex_branch_taken is re-presented after release.
2. ex_branch_taken: flush_ifid=1, bubble_idex=1, freeze_pc=0. The hazard is ignored because the ID instruction is being squashed.
3. hazard: freeze_pc=1, bubble_idex=1.
4. Otherwise all outputs are 0.

Scoreboard update on posedge clk when !freeze_all:
- WB <= MEM, MEM <= EX.
- EX <= ID fields when id_valid && !bubble_idex; otherwise EX <= invalid.

Stall counter:
- stall_cycles increments every cycle freeze_pc=1.
- It saturates at all-ones and does not wrap.

Register $0:
- $0 as a destination never hazards.
- $0 as a source never stalls.

Reset mid-operation:
- Asserting rst in MEM_WAIT returns the FSM to RUN immediately.
- It also clears the scoreboard and the counter.

Decomposition:
- Shared package pipe_ctrl_pkg: sb_entry_t struct {valid, wb_en, mem_read, dest}, the REG_AW default, the FSM state enum {RUN, MEM_WAIT} and the NOP/zero entry constant.
- One natural sub-module: hazard_scoreboard, holding the three-entry shift register plus the match logic.
- The top level holds the FSM, output priority and counter.

Test Plan:
1. FORWARD_EN=0: add r3 in ID, next cycle ID reads src1=3 → freeze_pc=1 and bubble_idex=1 for 3 cycles (EX, MEM, WB), then 0; stall_cycles=3.
2. FORWARD_EN=1: lw r5 followed by add reading r5 as src2 with id_two_src=1 → exactly 1 stall cycle. The same add with id_two_src=0 (immediate form) → 0 stalls.
3. Dest r0 written, then r0 read → no stall in either FORWARD_EN setting.
4. mem_req=1, mem_ready=0 for 4 cycles then 1 → freeze_all high for 4 cycles, FSM reaches MEM_WAIT and returns to RUN; scoreboard contents unchanged across the wait.
5. ex_branch_taken=1 in the same cycle as a RAW hazard → flush_ifid=1, bubble_idex=1, freeze_pc=0, counter unchanged. Then branch with freeze_all=1 → no flush until mem_ready.
6. Force stall_cycles to 16'hFFFE, stall 3 cycles → holds 16'hFFFF. Assert rst in MEM_WAIT → all outputs 0 and state RUN at the next edge.
